execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 219 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the RV32IM pipeline: single-cycle ALU plus an iterative
// shift-add multiplier / restoring divider that stalls decode while it runs.
module execute_stage #(
  parameter int CONTROL_BIT = 8,
  parameter int MD_ITER     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            dec_instr_i,
  input  logic [CONTROL_BIT-1:0] dec_control_i,
  input  logic [4:0]             dec_aluOp_i,
  input  logic                   dec_aSel_i,
  input  logic                   dec_bSel_i,
  input  logic [31:0]            dec_rs1_i,
  input  logic [31:0]            dec_rs2_i,
  input  logic [31:0]            dec_imm_i,
  input  logic [31:0]            dec_pc_i,
  input  logic [31:0]            dec_rd_addr_i,
  output logic                   dec_ready_o,
  output logic [31:0]            mem_instr_o,
  output logic [CONTROL_BIT-1:0] mem_control_o,
  output logic [31:0]            mem_aluResult_o,
  output logic [31:0]            mem_data_o,
  output logic [31:0]            mem_rd_addr_o,
  output logic [31:0]            mem_pcplus_o,
  input  logic                   mem_ready_i
);

  localparam logic [31:0]            I_NOP       = 32'h0000_0013;
  localparam logic [CONTROL_BIT-1:0] CONTROL_NOP = '0;
  localparam logic [4:0]             LAST_ITER   = 5'(MD_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [2:0]               op_q, op_d;
  logic [63:0]              acc_q, acc_d;
  logic [31:0]              opnd_q, opnd_d;
  logic                     neg_q, neg_d;
  logic                     rneg_q, rneg_d;
  logic [31:0]              instr_q, instr_d;
  logic [CONTROL_BIT-1:0]   ctrl_q, ctrl_d;
  logic [31:0]              res_q, res_d;
  logic [31:0]              data_q, data_d;
  logic [31:0]              rd_q, rd_d;
  logic [31:0]              pcp_q, pcp_d;

  logic [31:0] op_a, op_b, alu_res, mag_a, mag_b, md_res, quo, rem;
  logic [63:0] prod, mul_step, div_step;
  logic [32:0] mul_sum, div_r, div_diff;
  logic [2:0]  m_op;
  logic        is_m, signed_a, signed_b, sign_a, sign_b, div_zero, div_ovf;

  assign op_a = dec_aSel_i ? dec_pc_i  : dec_rs1_i;
  assign op_b = dec_bSel_i ? dec_imm_i : dec_rs2_i;
  assign is_m = (dec_aluOp_i[4:3] == 2'b10);
  assign m_op = dec_aluOp_i[2:0];

  always_comb begin
    case (dec_aluOp_i)
      5'd1:    alu_res = op_a - op_b;
      5'd2:    alu_res = op_a << op_b[4:0];
      5'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      5'd4:    alu_res = {31'b0, op_a < op_b};
      5'd5:    alu_res = op_a ^ op_b;
      5'd6:    alu_res = op_a >> op_b[4:0];
      5'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
      5'd8:    alu_res = op_a | op_b;
      5'd9:    alu_res = op_a & op_b;
      5'd10:   alu_res = op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  // Divides are signed when op[0]==0; multiplies take A signed except MULHU, B signed only for MUL/MULH.
  assign signed_a = m_op[2] ? ~m_op[0] : (m_op != 3'd3);
  assign signed_b = m_op[2] ? ~m_op[0] : ~m_op[1];
  assign sign_a   = signed_a & op_a[31];
  assign sign_b   = signed_b & op_b[31];
  assign mag_a    = sign_a ? -op_a : op_a;
  assign mag_b    = sign_b ? -op_b : op_b;
  assign div_zero = m_op[2] && (op_b == 32'd0);
  assign div_ovf  = m_op[2] && !m_op[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
  assign div_r    = acc_q[63:31];
  assign div_diff = div_r - {1'b0, opnd_q};
  assign div_step = div_diff[32] ? {div_r[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign prod = neg_q  ? -acc_q         : acc_q;
  assign quo  = neg_q  ? -acc_q[31:0]   : acc_q[31:0];
  assign rem  = rneg_q ? -acc_q[63:32]  : acc_q[63:32];

  always_comb begin
    case (op_q)
      3'd0:       md_res = prod[31:0];
      3'd1, 3'd2,
      3'd3:       md_res = prod[63:32];
      3'd4, 3'd5: md_res = quo;
      default:    md_res = rem;
    endcase
  end

  assign dec_ready_o = mem_ready_i && ((state_q == S_DONE) || ((state_q == S_IDLE) && !is_m));

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    instr_d = instr_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    data_d  = data_q;
    rd_d    = rd_q;
    pcp_d   = pcp_q;

    case (state_q)
      S_IDLE: begin
        if (is_m) begin
          op_d  = m_op;
          cnt_d = 5'd0;
          if (div_zero) begin
            acc_d   = {op_a, 32'hFFFF_FFFF};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else if (div_ovf) begin
            acc_d   = {32'd0, 32'h8000_0000};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            acc_d   = {32'd0, m_op[2] ? mag_a : mag_b};
            opnd_d  = m_op[2] ? mag_b : mag_a;
            neg_d   = sign_a ^ sign_b;
            rneg_d  = sign_a;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
      S_DONE: begin
        if (mem_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_ready_i) begin
      if (state_q == S_BUSY || (state_q == S_IDLE && is_m)) begin
        instr_d = I_NOP;
        ctrl_d  = CONTROL_NOP;
        res_d   = 32'd0;
        data_d  = 32'd0;
        rd_d    = 32'd0;
        pcp_d   = 32'd0;
      end else begin
        instr_d = dec_instr_i;
        ctrl_d  = dec_control_i;
        res_d   = (state_q == S_DONE) ? md_res : alu_res;
        data_d  = dec_rs2_i;
        rd_d    = dec_rd_addr_i;
        pcp_d   = dec_pc_i + 32'd4;
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      instr_q <= I_NOP;
      ctrl_q  <= CONTROL_NOP;
      res_q   <= 32'd0;
      data_q  <= 32'd0;
      rd_q    <= 32'd0;
      pcp_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      pcp_q   <= pcp_d;
    end
  end

  assign mem_instr_o     = instr_q;
  assign mem_control_o   = ctrl_q;
  assign mem_aluResult_o = res_q;
  assign mem_data_o      = data_q;
  assign mem_rd_addr_o   = rd_q;
  assign mem_pcplus_o    = pcp_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, multiply/divide latency and
// special cases, backpressure in DONE and asynchronous reset mid-divide.
module tb_execute_stage;

  localparam int          CB    = 8;
  localparam logic [31:0] I_NOP = 32'h0000_0013;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4,
                         XOR = 5'd5, SRA = 5'd7, PASSB = 5'd10, ADDX = 5'd12,
                         MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19,
                         DIV = 5'd20, DIVU = 5'd21, REM = 5'd22;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   dec_instr_i;
  logic [CB-1:0] dec_control_i;
  logic [4:0]    dec_aluOp_i;
  logic          dec_aSel_i, dec_bSel_i;
  logic [31:0]   dec_rs1_i, dec_rs2_i, dec_imm_i, dec_pc_i, dec_rd_addr_i;
  logic          dec_ready_o;
  logic [31:0]   mem_instr_o;
  logic [CB-1:0] mem_control_o;
  logic [31:0]   mem_aluResult_o, mem_data_o, mem_rd_addr_o, mem_pcplus_o;
  logic          mem_ready_i;

  int total = 0;
  int bad   = 0;
  int acc_cnt;

  execute_stage #(.CONTROL_BIT(CB), .MD_ITER(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_instr_i(dec_instr_i), .dec_control_i(dec_control_i), .dec_aluOp_i(dec_aluOp_i),
    .dec_aSel_i(dec_aSel_i), .dec_bSel_i(dec_bSel_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_ready_o(dec_ready_o),
    .mem_instr_o(mem_instr_o), .mem_control_o(mem_control_o), .mem_aluResult_o(mem_aluResult_o),
    .mem_data_o(mem_data_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_pcplus_o(mem_pcplus_o),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] instr);
    dec_aluOp_i   = op;
    dec_rs1_i     = a;
    dec_rs2_i     = b;
    dec_instr_i   = instr;
    dec_aSel_i    = 1'b0;
    dec_bSel_i    = 1'b0;
    dec_imm_i     = 32'd0;
    dec_pc_i      = 32'h200;
    dec_control_i = 8'h20;
    dec_rd_addr_i = {27'd0, op};
  endtask

  // Presents an M op at a falling edge and checks readiness, the bubble before
  // the result, and the result itself `lat` cycles later.
  task automatic run_m(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] instr,
                       input logic [31:0] expected, input int lat);
    present(op, a, b, instr);
    #1 check({tag, "_rdy_c0"}, dec_ready_o, 1'b0);
    repeat (lat - 1) @(negedge clk_i);
    check({tag, "_bubble_before"}, mem_instr_o, I_NOP);
    check({tag, "_rdy_done"}, dec_ready_o, 1'b1);
    @(negedge clk_i);
    check({tag, "_result"}, mem_aluResult_o, expected);
    check({tag, "_instr"}, mem_instr_o, instr);
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    present(ADD, 32'd0, 32'd0, I_NOP);
    repeat (2) @(negedge clk_i);
    check("rst_instr", mem_instr_o, I_NOP);
    check("rst_control", {24'd0, mem_control_o}, 32'd0);
    check("rst_result", mem_aluResult_o, 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    check("rst_rd", mem_rd_addr_o, 32'd0);
    check("rst_pcplus", mem_pcplus_o, 32'd0);
    rst_i = 1'b0;

    // Back-to-back single-cycle ops.
    present(SUB, 32'd5, 32'd7, 32'h40c5_8533);
    dec_pc_i = 32'h100;
    #1 check("sub_rdy", dec_ready_o, 1'b1);
    @(negedge clk_i);
    check("sub_result", mem_aluResult_o, 32'hFFFF_FFFE);
    check("sub_pcplus", mem_pcplus_o, 32'h104);
    check("sub_data", mem_data_o, 32'd7);
    check("sub_instr", mem_instr_o, 32'h40c5_8533);
    check("sub_rd", mem_rd_addr_o, 32'd1);
    present(SRA, 32'h8000_0000, 32'h55, 32'h4045_d513);
    dec_bSel_i = 1'b1;
    dec_imm_i  = 32'd4;
    @(negedge clk_i);
    check("sra_result", mem_aluResult_o, 32'hF800_0000);
    check("sra_data", mem_data_o, 32'h55);
    present(SLTU, 32'd1, 32'hFFFF_FFFF, 32'h00b5_3533);
    @(negedge clk_i);
    check("sltu_result", mem_aluResult_o, 32'd1);
    present(SLT, 32'hFFFF_FFFF, 32'd1, 32'h00b5_2533);
    @(negedge clk_i);
    check("slt_result", mem_aluResult_o, 32'd1);
    present(SLL, 32'd1, 32'd31, 32'h00b5_1533);
    @(negedge clk_i);
    check("sll_result", mem_aluResult_o, 32'h8000_0000);
    present(PASSB, 32'd9, 32'd0, 32'hdead_b537);
    dec_bSel_i = 1'b1;
    dec_imm_i  = 32'hDEAD_B000;
    @(negedge clk_i);
    check("passb_result", mem_aluResult_o, 32'hDEAD_B000);
    present(ADDX, 32'd2, 32'd3, 32'h0000_0033);
    @(negedge clk_i);
    check("code12_add", mem_aluResult_o, 32'd5);
    present(ADD, 32'd0, 32'd0, 32'h0200_0097);
    dec_aSel_i    = 1'b1;
    dec_bSel_i    = 1'b1;
    dec_pc_i      = 32'h1000;
    dec_imm_i     = 32'h20;
    dec_control_i = 8'hC0;
    @(negedge clk_i);
    check("auipc_result", mem_aluResult_o, 32'h1020);
    check("auipc_control", {24'd0, mem_control_o}, 32'hC0);

    // Backpressure on a single-cycle op holds the previous payload.
    mem_ready_i = 1'b0;
    present(XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h00b5_4533);
    #1 check("xor_stall_rdy", dec_ready_o, 1'b0);
    @(negedge clk_i);
    check("xor_stall_hold", mem_aluResult_o, 32'h1020);
    mem_ready_i = 1'b1;
    #1 check("xor_rdy", dec_ready_o, 1'b1);
    @(negedge clk_i);
    check("xor_result", mem_aluResult_o, 32'h0000_0FF0);

    // MULH -2*3 with per-cycle bubble and readiness checks.
    present(MULH, 32'hFFFF_FFFE, 32'd3, 32'h02b5_1533);
    #1 check("mulh_rdy_c0", dec_ready_o, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk_i);
      check($sformatf("mulh_nop_c%0d", k), mem_instr_o, I_NOP);
      check($sformatf("mulh_rdy_c%0d", k), dec_ready_o, (k == 33));
    end
    @(negedge clk_i);
    check("mulh_result", mem_aluResult_o, 32'hFFFF_FFFF);

    run_m("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h02b5_2533, 32'hFFFF_FFFF, 34);
    run_m("mul",    MUL,    32'd7,         32'd6,         32'h02b5_0533, 32'd42,        34);
    run_m("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h02b5_3533, 32'hFFFF_FFFE, 34);

    // Divide special cases complete in two cycles; general case in 34.
    run_m("div0",    DIV, 32'd7,         32'd0,         32'h02b5_4533, 32'hFFFF_FFFF, 2);
    run_m("rem0",    REM, 32'd7,         32'd0,         32'h02b5_6533, 32'd7,         2);
    run_m("divovf",  DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h02b5_4533, 32'h8000_0000, 2);
    run_m("removf",  REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h02b5_6533, 32'd0,         2);
    run_m("rem_m7",  REM, 32'hFFFF_FFF9, 32'd2,         32'h02b5_6533, 32'hFFFF_FFFF, 34);
    run_m("div_m7",  DIV, 32'hFFFF_FFF9, 32'd2,         32'h02b5_4533, 32'hFFFF_FFFD, 34);

    // DIVU 100/7 with mem_ready low for five DONE cycles.
    acc_cnt = 0;
    present(DIVU, 32'd100, 32'd7, 32'h02b5_5533);
    #1 if (dec_ready_o) acc_cnt++;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      if (dec_ready_o) acc_cnt++;
    end
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1 check("bp_rdy_low_c33", dec_ready_o, 1'b0);
    for (int k = 34; k <= 38; k++) begin
      @(negedge clk_i);
      check($sformatf("bp_frozen_instr_c%0d", k), mem_instr_o, I_NOP);
      check($sformatf("bp_frozen_res_c%0d", k), mem_aluResult_o, 32'd0);
      if (k < 38) check($sformatf("bp_rdy_low_c%0d", k), dec_ready_o, 1'b0);
    end
    mem_ready_i = 1'b1;
    #1 if (dec_ready_o) acc_cnt++;
    @(negedge clk_i);
    check("bp_result", mem_aluResult_o, 32'd14);
    check("bp_instr", mem_instr_o, 32'h02b5_5533);
    check("bp_accept_once", acc_cnt, 32'd1);
    present(ADD, 32'd1, 32'd1, 32'h00b5_0533);
    #1 check("bp_next_rdy", dec_ready_o, 1'b1);
    @(negedge clk_i);
    check("bp_next_result", mem_aluResult_o, 32'd2);
    check("bp_next_instr", mem_instr_o, 32'h00b5_0533);

    // Asynchronous reset ten cycles into a DIV.
    present(ADD, 32'd8, 32'd8, 32'h0000_0533);
    @(negedge clk_i);
    check("pre_div_result", mem_aluResult_o, 32'd16);
    present(DIV, 32'd1000, 32'd3, 32'h02b5_4533);
    repeat (10) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid_instr", mem_instr_o, I_NOP);
    check("rstmid_control", {24'd0, mem_control_o}, 32'd0);
    check("rstmid_result", mem_aluResult_o, 32'd0);
    check("rstmid_pcplus", mem_pcplus_o, 32'd0);
    present(ADD, 32'd3, 32'd4, 32'h0000_0533);
    #1 check("rstmid_idle_rdy", dec_ready_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_add_result", mem_aluResult_o, 32'd7);
    check("rstmid_add_pcplus", mem_pcplus_o, 32'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
